// File: rtl/pc_fetch_if.sv
// Fetch-side bus bundle for pc_fetch.
// Carries the instruction-memory request/response channel and the
// instruction handoff to decode.
//   imem_req    fetch request (driven by pc_fetch)
//   imem_addr   fetch word address (driven by pc_fetch)
//   imem_gnt    memory accepted the request this cycle
//   imem_rvalid read data valid this cycle
//   imem_rdata  instruction word from memory
//   inst_valid  inst holds a valid instruction (driven by pc_fetch)
//   inst        fetched instruction (driven by pc_fetch)
//   inst_ready  decode consumes inst this cycle
interface pc_fetch_if;
    logic        imem_req;
    logic [31:2] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, inst_valid, inst,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );

    // Memory/decode side
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready
    );
endinterface

// File: rtl/pc_fetch.sv
// PC register and single-outstanding instruction fetch unit.
// Holds the architectural PC, fetches one word per step, hands it to decode
// under valid/ready, supports forced redirects and counts memory stalls.
//   clk          clock, all state on rising edge
//   rst          synchronous reset, active-high
//   npc          next word address computed from pc
//   pc           current word address
//   redirect     force pc to redirect_pc and flush the fetch
//   redirect_pc  redirect target word address
//   stall_cnt    saturating count of memory-stall cycles
//   bus          memory request/response and decode handoff (master side)
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:2]      npc,
    output logic [31:2]      pc,
    input  logic             redirect,
    input  logic [31:2]      redirect_pc,
    output logic [CNT_W-1:0] stall_cnt,
    pc_fetch_if.master       bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:2]       pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic              valid_q, valid_d;
    logic              discard_q, discard_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q;
    logic              stall;

    // A stall is any cycle spent waiting on memory, including flushed responses
    assign stall = ((state_q == REQ)  && !bus.imem_gnt) ||
                   ((state_q == WAIT) && !bus.imem_rvalid);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC[31:2];
            inst_q    <= 32'h0;
            valid_q   <= 1'b0;
            discard_q <= 1'b0;
            cnt_q     <= '0;
            req_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            valid_q   <= valid_d;
            discard_q <= discard_d;
            cnt_q     <= cnt_d;
            req_q     <= (state_d == REQ);
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        valid_d   = valid_q;
        discard_d = discard_q;
        cnt_d     = cnt_q;

        if (stall && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (bus.imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    if (discard_q) begin
                        // Response belongs to a flushed request
                        state_d   = IDLE;
                        discard_d = 1'b0;
                    end else begin
                        state_d = HOLD;
                        inst_d  = bus.imem_rdata;
                        valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.inst_ready) begin
                    state_d = REQ;
                    pc_d    = npc;
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides everything; an in-flight request is marked for discard
        if (redirect) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            inst_d  = inst_q;
            case (state_q)
                REQ: begin
                    if (bus.imem_gnt) begin
                        state_d   = WAIT;
                        discard_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        state_d   = IDLE;
                        discard_d = 1'b0;
                    end else begin
                        state_d   = WAIT;
                        discard_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign pc             = pc_q;
    assign stall_cnt      = cnt_q;
    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = valid_q;
    assign bus.inst       = inst_q;

endmodule
